block_exp_normalizer: RTL and testbench

BLOCK_EXP_NORMALIZER -- requirements
Module: block_exp_normalizer

---
 rtl/block_exp_normalizer.sv | 121 ++++++++++++
 tb/tb_block_exp_normalizer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_exp_normalizer.sv
// block_exp_normalizer: collects a frame of exponent beats, then emits each beat re-biased against the frame maximum.
// Optional macro BLKEXP_UFLOW_CNT_EN adds the uflow_cnt output.
module block_exp_normalizer #(
  parameter int EXP_WIDTH = 4,
  parameter int LANES = 64,
  parameter int BEATS = 4,
  parameter int BIAS = 2 ** (EXP_WIDTH - 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*EXP_WIDTH-1:0] in_exp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*EXP_WIDTH-1:0] out_exp,
  output logic [EXP_WIDTH-1:0]       out_blk_exp,
  output logic                       out_last
`ifdef BLKEXP_UFLOW_CNT_EN
  ,
  output logic [$clog2(LANES*BEATS+1)-1:0] uflow_cnt
`endif
);
  localparam int W = LANES * EXP_WIDTH;
  localparam int IW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int EMAX = 2 ** EXP_WIDTH - 1;
  typedef enum logic {COLLECT, EMIT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [EXP_WIDTH-1:0] max_q, max_d, blk_q, blk_d, beat_max;
  logic [W-1:0] frame_q [BEATS];
  logic [W-1:0] cur;
  logic acc, hs;

  // Signed distance below the re-biased maximum; e never exceeds m so the range stays small.
  function automatic int bias_diff(input logic [EXP_WIDTH-1:0] e, input logic [EXP_WIDTH-1:0] m);
    return int'(e) + BIAS - int'(m);
  endfunction

  function automatic logic [EXP_WIDTH-1:0] norm(input logic [EXP_WIDTH-1:0] e, input logic [EXP_WIDTH-1:0] m);
    int t;
    t = bias_diff(e, m);
    return (e == '0 || t < 0) ? '0 : t > EMAX ? '1 : t[EXP_WIDTH-1:0];
  endfunction

  assign in_ready = state_q == COLLECT;
  assign out_valid = state_q == EMIT;
  assign out_last = out_valid && rd_q == IW'(BEATS - 1);
  assign out_blk_exp = blk_q;
  assign acc = in_valid && in_ready;
  assign hs = out_valid && out_ready;

  always_comb begin
    beat_max = max_q;
    out_exp = '0;
    cur = frame_q[rd_q];
    for (int i = 0; i < LANES; i++) begin
      beat_max = in_exp[i*EXP_WIDTH +: EXP_WIDTH] > beat_max ? in_exp[i*EXP_WIDTH +: EXP_WIDTH] : beat_max;
      out_exp[i*EXP_WIDTH +: EXP_WIDTH] = norm(cur[i*EXP_WIDTH +: EXP_WIDTH], blk_q);
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    rd_d = rd_q;
    max_d = max_q;
    blk_d = blk_q;
    if (acc) begin
      max_d = beat_max;
      wr_d = wr_q == IW'(BEATS - 1) ? '0 : wr_q + 1'b1;
      blk_d = wr_q == IW'(BEATS - 1) ? beat_max : blk_q;
      state_d = wr_q == IW'(BEATS - 1) ? EMIT : COLLECT;
    end
    if (hs) begin
      rd_d = out_last ? '0 : rd_q + 1'b1;
      max_d = out_last ? '0 : max_q;
      state_d = out_last ? COLLECT : EMIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      wr_q <= '0;
      rd_q <= '0;
      max_q <= '0;
      blk_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      max_q <= max_d;
      blk_q <= blk_d;
    end
  end

  // Frame storage carries no reset; it is only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (acc) frame_q[wr_q] <= in_exp;
  end

`ifdef BLKEXP_UFLOW_CNT_EN
  localparam int CW = $clog2(LANES * BEATS + 1);
  logic [CW-1:0] uflow_q, uflow_d, uflow_beat;

  // The presented beat's underflows are folded in so the full frame total shows alongside out_last.
  always_comb begin
    uflow_beat = '0;
    for (int i = 0; i < LANES; i++)
      uflow_beat = uflow_beat + CW'(cur[i*EXP_WIDTH +: EXP_WIDTH] != '0 && bias_diff(cur[i*EXP_WIDTH +: EXP_WIDTH], blk_q) < 0);
    uflow_d = hs ? (out_last ? '0 : uflow_q + uflow_beat) : uflow_q;
    uflow_cnt = out_valid ? uflow_q + uflow_beat : uflow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) uflow_q <= '0;
    else uflow_q <= uflow_d;
  end
`endif
endmodule

// File: tb/tb_block_exp_normalizer.sv
// tb_block_exp_normalizer: directed frames checked every cycle against a frame-level model,
// plus hand-computed literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_block_exp_normalizer;
  localparam int EW = 4;
  localparam int L = 4;
  localparam int B = 2;
  localparam int BI = 8;

  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0;
  logic out_ready = 1;
  logic in_ready, out_valid, out_last;
  logic [L*EW-1:0] in_exp = '0;
  logic [L*EW-1:0] out_exp;
  logic [EW-1:0] out_blk_exp;
`ifdef BLKEXP_UFLOW_CNT_EN
  logic [$clog2(L*B+1)-1:0] uflow_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [L*EW-1:0] e;
    logic [EW-1:0] b;
    logic l;
    int u;
  } exp_t;
  exp_t exp_q[$];
  logic [L*EW-1:0] part[$];

  block_exp_normalizer #(.EXP_WIDTH(EW), .LANES(L), .BEATS(B), .BIAS(BI)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_exp(in_exp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_exp(out_exp),
    .out_blk_exp(out_blk_exp),
    .out_last(out_last)
`ifdef BLKEXP_UFLOW_CNT_EN
    ,
    .uflow_cnt(uflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Model: whole frame in hand, take the max over every lane, re-bias with plain integer arithmetic.
  function automatic void model_frame();
    int m, u, e, t;
    exp_t x;
    m = 0;
    u = 0;
    foreach (part[k])
      for (int i = 0; i < L; i++)
        if (int'(part[k][i*EW +: EW]) > m) m = int'(part[k][i*EW +: EW]);
    foreach (part[k]) begin
      x.e = '0;
      for (int i = 0; i < L; i++) begin
        e = int'(part[k][i*EW +: EW]);
        t = e + BI - m;
        if (e != 0 && t < 0) u++;
        x.e[i*EW +: EW] = EW'((e == 0 || t < 0) ? 0 : (t > 15 ? 15 : t));
      end
      x.b = EW'(m);
      x.l = (k == B - 1);
      x.u = u;
      exp_q.push_back(x);
    end
    part.delete();
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      part.delete();
      exp_q.delete();
    end else begin
      check("ready_xor_valid", in_ready, !out_valid);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: out_valid=1 with no expected beat at %0t", $time);
        end else begin
          check("model_exp", out_exp, exp_q[0].e);
          check("model_blk", out_blk_exp, exp_q[0].b);
          check("model_last", out_last, exp_q[0].l);
`ifdef BLKEXP_UFLOW_CNT_EN
          if (out_last) check("model_uflow", uflow_cnt, exp_q[0].u);
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        part.push_back(in_exp);
        if (part.size() == B) model_frame();
      end
    end
  end

  // Called 1ns after a rising edge; returns 1ns after the edge that accepts the beat.
  task automatic put_beat(input logic [L*EW-1:0] d);
    int n;
    n = 0;
    in_valid = 1;
    in_exp = d;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles", n);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_blk", out_blk_exp, 0);

    // {12,5,3,0},{1,2,2,7}: max 12, outputs {8,1,0,0},{0,0,0,3}
    put_beat(16'h035C);
    put_beat(16'h7221);
    check("f1_valid_next", out_valid, 1);
    check("f1_ready_low", in_ready, 0);
    check("f1_b0_exp", out_exp, 16'h0018);
    check("f1_blk", out_blk_exp, 12);
    check("f1_b0_last", out_last, 0);
    step();
    check("f1_b1_exp", out_exp, 16'h3000);
    check("f1_b1_last", out_last, 1);
    check("f1_b1_ready_low", in_ready, 0);
`ifdef BLKEXP_UFLOW_CNT_EN
    check("f1_uflow_last", uflow_cnt, 4);
`endif
    step();
    check("f1_back_ready", in_ready, 1);
    check("f1_back_valid", out_valid, 0);
`ifdef BLKEXP_UFLOW_CNT_EN
    check("f1_uflow_clear", uflow_cnt, 0);
`endif

    // Stall: {15,15,1,0},{8,0,9,15}: max 15, outputs {8,8,0,0},{1,0,2,8}
    out_ready = 0;
    put_beat(16'h01FF);
    put_beat(16'hF908);
    repeat (5) begin
      check("stall_valid", out_valid, 1);
      check("stall_exp", out_exp, 16'h0088);
      check("stall_blk", out_blk_exp, 15);
      check("stall_last", out_last, 0);
      step();
    end
    out_ready = 1;
    check("stall_release_exp", out_exp, 16'h0088);
    step();
    check("stall_b1_exp", out_exp, 16'h8201);
    check("stall_b1_last", out_last, 1);
    step();

    // All-zero frame
    put_beat(16'h0000);
    put_beat(16'h0000);
    check("zero_blk", out_blk_exp, 0);
    check("zero_b0_exp", out_exp, 0);
    step();
    check("zero_b1_exp", out_exp, 0);
    check("zero_b1_last", out_last, 1);
    step();

    // Reset after one beat; that beat (max 15) must not leak into the next frame
    put_beat(16'hFFFF);
    rst = 1;
    step();
    rst = 0;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    // {3,1,0,2},{2,2,2,2}: max 3, outputs {8,6,0,7},{7,7,7,7}
    put_beat(16'h2013);
    put_beat(16'h2222);
    check("mid_rst_blk", out_blk_exp, 3);
    check("mid_rst_b0_exp", out_exp, 16'h7068);
    step();
    check("mid_rst_b1_exp", out_exp, 16'h7777);
    step();

    // Further frames checked by the model only
    put_beat(16'h0001);
    put_beat(16'h0000);
    put_beat(16'h8421);
    put_beat(16'h0010);
    put_beat(16'hA9B7);
    put_beat(16'h5F03);

    n = 0;
    while ((!in_ready || exp_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
